// File: rtl/src_pkg.sv
// Shared widths and FSM state encoding for the src_memory block.
package src_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/src_mem_array.sv
// DEPTH x 32 word storage: one asynchronous read port, one synchronous write port.
// Contents are never reset so preloaded programs survive a CPU reset.
module src_mem_array
    import src_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [MEM_DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [MEM_DATA_W-1:0] o_rdata
);

    logic [MEM_DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/src_memory.sv
// Word-addressed main memory on the CPU's tri-state bus with optional wait states,
// a side-band preload port (which always wins the write port) and a sticky range error.
module src_memory
    import src_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = MEM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [MEM_DATA_W-1:0] mem_bus,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  read,
    input  logic                  enable,
    output logic                  ready,
    input  logic                  load_en,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [MEM_DATA_W-1:0] load_data,
    output logic                  err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic                  w_acc_ok;
    logic                  w_load_ok;
    logic                  w_ready;
    logic                  w_we;
    logic [IDX_W-1:0]      w_waddr;
    logic [MEM_DATA_W-1:0] w_wdata;
    logic [MEM_DATA_W-1:0] w_rdata;
    logic                  r_err;

    assign w_acc_ok  = {1'b0, address}   < DEPTH_L;
    assign w_load_ok = {1'b0, load_addr} < DEPTH_L;

    generate
        if (WAIT_STATES == 0) begin : g_nowait
            assign w_ready = ~rst & enable & ~load_en;
        end else begin : g_wait
            localparam int CNT_W = $clog2(WAIT_STATES + 1);

            mem_state_t       r_state;
            logic [CNT_W-1:0] r_cnt;

            // Counter reaches DONE after WAIT_STATES-1 WAIT cycles, so the
            // transfer lands exactly WAIT_STATES cycles after the request.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    case (r_state)
                        IDLE: begin
                            if (enable) begin
                                if (WAIT_STATES == 1) begin
                                    r_state <= DONE;
                                end else begin
                                    r_state <= WAIT;
                                    r_cnt   <= CNT_W'(WAIT_STATES - 1);
                                end
                            end
                        end
                        WAIT: begin
                            if (!enable) begin
                                r_state <= IDLE;
                                r_cnt   <= '0;
                            end else if (r_cnt == CNT_W'(1)) begin
                                r_state <= DONE;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                        DONE: begin
                            if (!enable || !load_en) begin
                                r_state <= IDLE;
                            end
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end

            assign w_ready = ~rst & (r_state == DONE) & enable & ~load_en;
        end
    endgenerate

    assign ready = w_ready;

    assign w_we    = load_en ? w_load_ok : (w_ready & ~read & w_acc_ok);
    assign w_waddr = load_en ? load_addr[IDX_W-1:0] : address[IDX_W-1:0];
    assign w_wdata = load_en ? load_data : mem_bus;

    src_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (address[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    // Only drive during a read transfer so controller write data never collides.
    assign mem_bus = (enable & read & w_ready) ? (w_acc_ok ? w_rdata : '0) : 'z;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((load_en & ~w_load_ok) | (w_ready & ~w_acc_ok)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule

// File: tb/tb_src_memory.sv
// Directed bench: three src_memory instances (0, 2 and 3 wait states) share address/preload inputs.
module tb_src_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] address = '0;
    logic        read = 1'b0;
    logic        en0 = 1'b0, en2 = 1'b0, en3 = 1'b0;
    logic        load_en = 1'b0;
    logic [15:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        drv_en = 1'b0;
    logic [31:0] drv_dat = '0;

    wire  [31:0] bus0, bus2, bus3;
    logic        rdy0, rdy2, rdy3;
    logic        err0, err2, err3;

    int checks = 0;
    int errors = 0;

    assign bus0 = drv_en ? drv_dat : 'z;
    assign bus2 = drv_en ? drv_dat : 'z;
    assign bus3 = drv_en ? drv_dat : 'z;

    always #5 clk = ~clk;

    src_memory #(.DEPTH(4096), .WAIT_STATES(0), .ADDR_W(16)) u0 (
        .clk(clk), .rst(rst), .mem_bus(bus0), .address(address), .read(read),
        .enable(en0), .ready(rdy0), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .err(err0)
    );

    src_memory #(.DEPTH(4096), .WAIT_STATES(2), .ADDR_W(16)) u2 (
        .clk(clk), .rst(rst), .mem_bus(bus2), .address(address), .read(read),
        .enable(en2), .ready(rdy2), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .err(err2)
    );

    src_memory #(.DEPTH(4096), .WAIT_STATES(3), .ADDR_W(16)) u3 (
        .clk(clk), .rst(rst), .mem_bus(bus3), .address(address), .read(read),
        .enable(en3), .ready(rdy3), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .err(err3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en0 = 1'b1; read = 1'b1; address = 16'h0010;
        step(); step();
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rdy0); end
        checks++;
        if (err0 !== 1'b0 || err2 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b/%b expected 0/0", err0, err2); end
        checks++;
        if (!(bus0 === 32'hzzzz_zzzz || bus0 === 32'h0)) begin errors++; $display("FAIL reset_bus: got %h expected released", bus0); end
        en0 = 1'b0; rst = 1'b0;
        step();
    endtask

    task automatic test_preload();
        load_en = 1'b1; load_addr = 16'h0010; load_data = 32'hDEAD_BEEF;
        step();
        load_addr = 16'h0030; load_data = 32'h0BAD_0030;
        step();
        load_en = 1'b0;
    endtask

    task automatic test_read_ws0();
        en0 = 1'b1; read = 1'b1; address = 16'h0010;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL ws0_read_ready: got %b expected 1", rdy0); end
        checks++;
        if (bus0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws0_read_data: got %h expected deadbeef", bus0); end
        step();
        en0 = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b0) begin errors++; $display("FAIL ws0_idle_ready: got %b expected 0", rdy0); end
        checks++;
        if (!(bus0 === 32'hzzzz_zzzz || bus0 === 32'h0)) begin errors++; $display("FAIL ws0_release: got %h expected released", bus0); end
        step();
    endtask

    task automatic test_write_ws0();
        drv_en = 1'b1; drv_dat = 32'h1234_5678;
        en0 = 1'b1; read = 1'b0; address = 16'h0020;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL ws0_write_ready: got %b expected 1", rdy0); end
        step();
        drv_en = 1'b0; en0 = 1'b0;
        step();
        en0 = 1'b1; read = 1'b1; address = 16'h0020;
        @(negedge clk);
        checks++;
        if (bus0 !== 32'h1234_5678) begin errors++; $display("FAIL ws0_write_readback: got %h expected 12345678", bus0); end
        step();
        en0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        en0 = 1'b1; read = 1'b1; address = 16'h0010;
        @(negedge clk);
        checks++;
        if (bus0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_first: got %h expected deadbeef", bus0); end
        step();
        address = 16'h0020;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1 || bus0 !== 32'h1234_5678) begin errors++; $display("FAIL b2b_second: got rdy=%b data=%h expected rdy=1 data=12345678", rdy0, bus0); end
        step();
        en0 = 1'b0;
        step();
    endtask

    task automatic test_wait2();
        en2 = 1'b1; read = 1'b1; address = 16'h0010;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (rdy2 !== 1'b0) begin errors++; $display("FAIL ws2_wait_ready c%0d: got %b expected 0", c, rdy2); end
            checks++;
            if (!(bus2 === 32'hzzzz_zzzz || bus2 === 32'h0)) begin errors++; $display("FAIL ws2_wait_bus c%0d: got %h expected released", c, bus2); end
            step();
        end
        @(negedge clk);
        checks++;
        if (rdy2 !== 1'b1 || bus2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws2_xfer: got rdy=%b data=%h expected rdy=1 data=deadbeef", rdy2, bus2); end
        step();
        en2 = 1'b0;
        step();
    endtask

    task automatic test_abort_ws3();
        int lat;
        bit seen;
        drv_en = 1'b1; drv_dat = 32'hCAFE_0001;
        en3 = 1'b1; read = 1'b0; address = 16'h0030;
        @(negedge clk);
        checks++;
        if (rdy3 !== 1'b0) begin errors++; $display("FAIL ws3_abort_c0: got %b expected 0", rdy3); end
        step();
        en3 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rdy3 === 1'b1) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin errors++; $display("FAIL ws3_abort_ready: got asserted expected never"); end
        drv_en = 1'b0;
        en3 = 1'b1; read = 1'b1; address = 16'h0030;
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rdy3 === 1'b1) begin
                lat = c;
                checks++;
                if (bus3 !== 32'h0BAD_0030) begin errors++; $display("FAIL ws3_prior_value: got %h expected 0bad0030", bus3); end
                break;
            end
            step();
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL ws3_latency: got %0d expected 3 (-1 = timeout)", lat); end
        step();
        en3 = 1'b0;
        step();
    endtask

    task automatic test_oob();
        en0 = 1'b1; read = 1'b1; address = 16'h1000;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1 || bus0 !== 32'h0) begin errors++; $display("FAIL oob_read: got rdy=%b data=%h expected rdy=1 data=0", rdy0, bus0); end
        checks++;
        if (err0 !== 1'b0) begin errors++; $display("FAIL oob_err_early: got %b expected 0", err0); end
        step();
        en0 = 1'b0;
        @(negedge clk);
        checks++;
        if (err0 !== 1'b1) begin errors++; $display("FAIL oob_err_set: got %b expected 1", err0); end
        step(); step();
        @(negedge clk);
        checks++;
        if (err0 !== 1'b1) begin errors++; $display("FAIL oob_err_sticky: got %b expected 1", err0); end
        checks++;
        if (err2 !== 1'b0) begin errors++; $display("FAIL oob_err_other: got %b expected 0", err2); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (err0 !== 1'b0) begin errors++; $display("FAIL oob_err_clear: got %b expected 0", err0); end
        step();
        en0 = 1'b1; read = 1'b1; address = 16'h0010;
        @(negedge clk);
        checks++;
        if (bus0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oob_retain: got %h expected deadbeef", bus0); end
        step();
        en0 = 1'b0;
        load_en = 1'b1; load_addr = 16'h2000; load_data = 32'h1111_2222;
        step();
        load_en = 1'b0;
        @(negedge clk);
        checks++;
        if (err0 !== 1'b1) begin errors++; $display("FAIL oob_preload_err: got %b expected 1", err0); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_priority();
        load_en = 1'b1; load_addr = 16'h0040; load_data = 32'h5A5A_0040;
        en0 = 1'b1; read = 1'b1; address = 16'h0040;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b0) begin errors++; $display("FAIL load_prio_ready: got %b expected 0", rdy0); end
        checks++;
        if (!(bus0 === 32'hzzzz_zzzz || bus0 === 32'h0)) begin errors++; $display("FAIL load_prio_bus: got %h expected released", bus0); end
        step();
        load_en = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy0 !== 1'b1 || bus0 !== 32'h5A5A_0040) begin errors++; $display("FAIL load_prio_xfer: got rdy=%b data=%h expected rdy=1 data=5a5a0040", rdy0, bus0); end
        step();
        en0 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_preload();
        test_read_ws0();
        test_write_ws0();
        test_back_to_back();
        test_wait2();
        test_abort_ws3();
        test_oob();
        test_load_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/src_memory.md
Name: src_memory

Overview:
- Word-addressed 32-bit main memory on the external side of the CPU.
- Attaches to the CPU's shared tri-state `mem_bus`, 16-bit `address`, `read` and `enable` lines.
- Serves instruction fetches, loads (read) and stores (write).
- Configurable wait states with a `ready` handshake, a side-band preload port for programs and benches, and a sticky out-of-range error flag.

Parameters:
- DEPTH, 4096, number of 32-bit words implemented.
- WAIT_STATES, 0, extra cycles before `ready`. 0 gives a same-cycle response compatible with a CPU that holds `enable` for exactly one cycle.
- ADDR_W, 16, width of `address` and `load_addr`.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous active-high reset
- mem_bus  inout  32  shared data bus. Driven only during a read transfer, else 'z
- address  in  ADDR_W  word address from the CPU memory controller
- read  in  1  1 = read, 0 = write. Qualified by `enable`
- enable  in  1  access request, held high until `ready`
- ready  out  1  transfer happens this cycle
- load_en  in  1  preload write strobe
- load_addr  in  ADDR_W  preload word address
- load_data  in  32  preload data
- err  out  1  sticky: an access or preload hit an address >= DEPTH

Behaviour:
- Reset:
  - FSM goes to IDLE, wait counter to 0, `err` to 0, `mem_bus` released.
  - `ready` is 0 while `rst` is high.
  - Array contents are NOT cleared.
- FSM states:
  - IDLE: no access in progress.
  - WAIT: counting wait states.
  - DONE: transfer cycle.
- WAIT_STATES = 0:
  - FSM stays in IDLE.
  - `ready` = `enable` & ~`load_en` (combinational).
  - Every cycle with `ready` high is one complete transfer.
  - Back-to-back accesses are allowed.
- WAIT_STATES = N > 0:
  - Cycle 0 is the first cycle `enable` is sampled high in IDLE.
  - IDLE->WAIT at that posedge, with counter = N-1.
  - WAIT decrements the counter each cycle; at 0 it goes to DONE.
  - In DONE, `ready` = `enable` & ~`load_en`, so the transfer occurs in cycle N.
  - DONE->IDLE after the transfer.
  - If `enable` is still high, the next access starts counting in the following cycle.
  - If `load_en` is high in DONE, the FSM stays in DONE until the transfer completes.
- Read transfer (`ready` & `read`): `mem_bus` = array[`address`] combinationally during that cycle. This is an asynchronous array read.
- Write transfer (`ready` & ~`read`): array[`address`] <= `mem_bus` at the posedge ending that cycle.
- Requester obligations:
  - `address`, `read` and write data stay stable from cycle 0 through the `ready` cycle.
  - Violations are undefined.
- Abort: `enable` low before `ready` returns the FSM to IDLE next posedge. No write occurs and no data is driven.
- Reset mid-WAIT: access aborted, no write.
- Out of range (`address` >= DEPTH):
  - Read drives 32'h0000_0000.
  - Write is dropped.
  - `err` <= 1 at the posedge ending the transfer.
  - `ready` still asserts, so the requester never hangs.
- Preload:
  - `load_en` writes `load_data` to array[`load_addr`] at posedge.
  - Out-of-range preload is dropped and sets `err`.
  - `load_en` has priority: `ready` is held low that cycle and the bus access stretches by one cycle.
- Bus drive: never drive `mem_bus` unless `enable` & `read` & `ready`. This avoids contention with controller-driven write data.
- Index width: the array is indexed by `address`[$clog2(DEPTH)-1:0] after the range check on the full ADDR_W value.

Decomposition:
- src_pkg holds:
  - MEM_DATA_W = 32 and MEM_ADDR_W = 16.
  - The mem_state_t enum {IDLE, WAIT, DONE}.
- One sub-module, src_mem_array:
  - DEPTH x 32 storage.
  - One asynchronous read port.
  - One synchronous write port.
  - src_memory muxes preload against bus write into that port, with preload winning.

Test Plan:
- Preload 0x10 = 32'hDEAD_BEEF; WAIT_STATES=0; `enable`=1, `read`=1, `address`=0x10 for one cycle -> `ready`=1 and `mem_bus`=32'hDEAD_BEEF in that cycle; 'z the next cycle.
- WAIT_STATES=0; drive `mem_bus`=32'h1234_5678 with `enable`=1, `read`=0, `address`=0x20 for one cycle; then read 0x20 -> returns 32'h1234_5678.
- WAIT_STATES=2; read 0x10 held -> `ready` low in cycles 0-1, high in cycle 2 with 32'hDEAD_BEEF; `mem_bus` 'z in cycles 0-1.
- WAIT_STATES=3; write 32'hCAFE_0001 to 0x30 and drop `enable` in cycle 1 -> `ready` never asserts; a later read of 0x30 returns its prior value; FSM back in IDLE.
- DEPTH=4096; read 0x1000 -> `ready`=1, `mem_bus`=0, `err`=1 next cycle and stays 1 until `rst`; then `rst` -> `err`=0, and 0x10 still reads 32'hDEAD_BEEF.
- WAIT_STATES=0; `load_en` together with a bus read of 0x40 -> `ready`=0 that cycle and the preload is written; next cycle `ready`=1 and returns the new data.
